// File: rtl/mem_stage_lsu_pkg.sv
// ============================================================================
// Module      : mem_stage_lsu_pkg
// Description : Shared types and constants for the memory-stage LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Byte lane actually used: halves ignore a[0], words ignore both low bits.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SIZE_BYTE)      return addr_lo;
    else if (size == SIZE_HALF) return {addr_lo[1], 1'b0};
    else                        return 2'b00;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SIZE_HALF)      return addr_lo[0];
    else if (size == SIZE_WORD) return (addr_lo != 2'b00);
    else                        return 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_load_align_extend.sv
// ============================================================================
// Module      : load_align_extend
// Description : Shifts the addressed lane of read data down and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align_extend
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] lane_w;

  always_comb begin
    lane_w   = rdata_i >> {offset_i, 3'b000};
    result_o = lane_w;
    if (!funct3_i[1]) begin
      if (funct3_i[0]) begin
        result_o = {{16{lane_w[15] & ~funct3_i[2]}}, lane_w[15:0]};
      end else begin
        result_o = {{24{lane_w[7] & ~funct3_i[2]}}, lane_w[7:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : RV32I memory-stage load/store unit on a req/gnt/rvalid bus.
//               Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_memory_data,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_misaligned,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  lsu_state_e  state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        misaligned_q;

  logic        start_w;
  logic        trap_w;
  logic [1:0]  size_w;
  logic [1:0]  offset_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] extended_w;

  assign start_w  = (state_q == ST_IDLE) & i_valid & (i_mem_read | i_mem_write);
  assign size_w   = i_funct3[1] ? SIZE_WORD : i_funct3[1:0];
  assign offset_d = eff_offset(size_w, i_alu_result[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_w = is_misaligned(size_w, i_alu_result[1:0]);
`else
  assign trap_w = 1'b0;
`endif

  always_comb begin
    wdata_d = i_memory_data;
    wstrb_d = STRB_WORD;
    case (size_w)
      SIZE_BYTE: begin
        wdata_d = {4{i_memory_data[7:0]}};
        wstrb_d = STRB_BYTE << offset_d;
      end
      SIZE_HALF: begin
        wdata_d = {2{i_memory_data[15:0]}};
        wstrb_d = STRB_HALF << offset_d;
      end
      default: ;
    endcase
  end

  load_align_extend u_extend (
    .rdata_i  (i_bus_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .result_o (extended_w)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_w) begin
            funct3_q <= i_funct3;
            offset_q <= offset_d;
            if (trap_w) begin
              misaligned_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= i_mem_write;
              bus_addr_q  <= {i_alu_result[31:2], 2'b00};
              bus_wdata_q <= i_mem_write ? wdata_d : 32'd0;
              bus_wstrb_q <= i_mem_write ? wstrb_d : 4'd0;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_we_q ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_bus_rvalid) begin
            load_data_q  <= extended_w;
            load_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The EX/MEM register still shows this op; returning to IDLE without
          // sampling start prevents a replay.
          load_valid_q <= 1'b0;
          misaligned_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_stall      = start_w | (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign o_load_data  = load_data_q;
  assign o_load_valid = load_valid_q;
  assign o_misaligned = misaligned_q;
  assign o_bus_req    = bus_req_q;
  assign o_bus_we     = bus_we_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_bus_wstrb  = bus_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst, valid, mrd, mwr, gnt, rvalid;
  logic [2:0]  f3;
  logic [31:0] alu, mdata, rdata;
  logic        o_stall, o_load_valid, o_misaligned, o_bus_req, o_bus_we;
  logic [31:0] o_load_data, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_wstrb;

  int checks   = 0;
  int failures = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_read(mrd), .i_mem_write(mwr),
    .i_funct3(f3), .i_alu_result(alu), .i_memory_data(mdata),
    .o_stall(o_stall), .o_load_data(o_load_data), .o_load_valid(o_load_valid),
    .o_misaligned(o_misaligned), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
    .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, lane arithmetic on integers.
  function automatic int nbytes(input logic [2:0] fn);
    return fn[1] ? 4 : (fn[0] ? 2 : 1);
  endfunction

  function automatic int eff_off(input logic [2:0] fn, input logic [31:0] a);
    int n = nbytes(fn);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic bit is_mis(input logic [2:0] fn, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(fn)) != 0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] fn, input logic [31:0] d);
    logic [31:0] w;
    int n = nbytes(fn);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] fn, input logic [31:0] a);
    logic [3:0] s;
    int n   = nbytes(fn);
    int off = eff_off(fn, a);
    for (int k = 0; k < 4; k++) s[k] = (k >= off) && (k < off + n);
    return s;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rw);
    longint v   = 0;
    int     n   = nbytes(fn);
    int     off = eff_off(fn, a);
    for (int i = 0; i < n; i++) v = v | (longint'(rw[8*(off+i) +: 8]) << (8*i));
    if (!fn[2] && n < 4 && v >= (64'd1 << (8*n-1))) v = v - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  task automatic run_access(input bit wr, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] d, input int gd, input int rd,
                            input logic [31:0] rw);
    int stalls = 0;
    int exp_st;
    bit trap = TRAP && is_mis(fn, a);
    exp_st = trap ? 1 : (wr ? gd + 2 : gd + 2 + rd);
    @(negedge clk);
    valid = 1'b1; mrd = !wr; mwr = wr; f3 = fn; alu = a; mdata = d; gnt = 1'b0; rvalid = 1'b0;
    #1;
    if (o_stall) stalls++;
    chk("idle_req", o_bus_req, 0);
    if (!trap) begin
      for (int k = 0; k <= gd; k++) begin
        @(negedge clk); gnt = (k == gd); #1;
        if (o_stall) stalls++;
        chk("req", o_bus_req, 1);
        chk("addr", o_bus_addr, {a[31:2], 2'b00});
        chk("we", o_bus_we, wr);
        chk("wstrb", o_bus_wstrb, wr ? exp_wstrb(fn, a) : 4'd0);
        if (wr) chk("wdata", o_bus_wdata, exp_wdata(fn, d));
      end
      if (!wr) begin
        for (int k = 1; k <= rd; k++) begin
          @(negedge clk); gnt = 1'b0; rvalid = (k == rd); rdata = (k == rd) ? rw : $urandom; #1;
          if (o_stall) stalls++;
          chk("wait_req", o_bus_req, 0);
          chk("wait_lv", o_load_valid, 0);
        end
      end
    end
    @(negedge clk); gnt = 1'b0; rvalid = 1'b0; rdata = $urandom; #1;
    chk("done_stall", o_stall, 0);
    chk("done_req", o_bus_req, 0);
    chk("done_lv", o_load_valid, !wr && !trap);
    chk("done_mis", o_misaligned, trap);
    if (!wr && !trap) chk("load_data", o_load_data, exp_load(fn, a, rw));
    chk("stall_cycles", stalls, exp_st);
    @(negedge clk); valid = 1'b0; mrd = 1'b0; mwr = 1'b0; #1;
    chk("post_stall", o_stall, 0);
    chk("post_lv", o_load_valid, 0);
    chk("post_req", o_bus_req, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_req"}, o_bus_req, 0);
    chk({tag, "_we"}, o_bus_we, 0);
    chk({tag, "_addr"}, o_bus_addr, 0);
    chk({tag, "_wdata"}, o_bus_wdata, 0);
    chk({tag, "_wstrb"}, o_bus_wstrb, 0);
    chk({tag, "_ldata"}, o_load_data, 0);
    chk({tag, "_lv"}, o_load_valid, 0);
    chk({tag, "_mis"}, o_misaligned, 0);
  endtask

  initial begin
    logic [2:0] ld_ops [5];
    ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1; valid = 1'b0; mrd = 1'b0; mwr = 1'b0; f3 = 3'b0; alu = '0; mdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk_all_zero("reset");

    run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_access(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0);
    run_access(1'b0, 3'b000, 32'h202, 32'h0, 0, 1, 32'h12803456);
    run_access(1'b0, 3'b100, 32'h202, 32'h0, 0, 1, 32'h12803456);
    run_access(1'b0, 3'b001, 32'h202, 32'h0, 0, 1, 32'h12803456);
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 3, 2, 32'hCAFEF00D);
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 32'h89ABCDEF);
    run_access(1'b1, 3'b001, 32'h401, 32'h00001234, 1, 0, 32'h0);

    // Valid but neither read nor write, and invalid with read: no activity.
    @(negedge clk); valid = 1'b1; mrd = 1'b0; mwr = 1'b0; #1;
    chk("nop_stall", o_stall, 0);
    @(negedge clk); valid = 1'b0; mrd = 1'b1; #1;
    chk("bubble_stall", o_stall, 0);
    @(negedge clk); #1;
    chk("bubble_req", o_bus_req, 0);
    mrd = 1'b0;

    // Reset during WAIT; late rvalid must be ignored.
    @(negedge clk); valid = 1'b1; mrd = 1'b1; f3 = 3'b010; alu = 32'h40; #1;
    @(negedge clk); gnt = 1'b1; #1;
    @(negedge clk); gnt = 1'b0; valid = 1'b0; mrd = 1'b0; rst = 1'b1; #1;
    chk("rstw_req", o_bus_req, 0);
    @(negedge clk); rst = 1'b0; rvalid = 1'b1; rdata = 32'h55AA55AA; #1;
    chk_all_zero("rst_wait");
    @(negedge clk); rvalid = 1'b0; #1;
    chk_all_zero("rst_wait2");

    // Reset during REQ: request drops on the next cycle.
    @(negedge clk); valid = 1'b1; mwr = 1'b1; f3 = 3'b010; alu = 32'h80; mdata = 32'h1; #1;
    @(negedge clk); rst = 1'b1; valid = 1'b0; mwr = 1'b0; #1;
    chk("rstr_req_before", o_bus_req, 1);
    @(negedge clk); rst = 1'b0; rvalid = 1'b1; #1;
    chk_all_zero("rst_req");
    @(negedge clk); rvalid = 1'b0; #1;

    for (int i = 0; i < 40; i++) begin
      bit          wr = $urandom_range(1);
      logic [2:0]  fn = wr ? 3'($urandom_range(2)) : ld_ops[$urandom_range(4)];
      run_access(wr, fn, $urandom, $urandom, $urandom_range(3), $urandom_range(3, 1), $urandom);
      repeat ($urandom_range(2)) begin
        @(negedge clk); #1;
        chk("gap_stall", o_stall, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the pipelined RV32I core: receives the address (ALU result), store data and access type from the execute→memory pipeline register, and drives a request/grant/rvalid data bus. It aligns store data and byte strobes, extracts and sign/zero-extends load data, and stalls the pipeline until each access completes.

## Interface
- No parameters; widths fixed (XLEN 32, 4 byte lanes).
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  memory-stage instruction valid (not a bubble).
- i_mem_read / i_mem_write  in  1 each  load / store; never both high.
- i_funct3  in  3  access type: [1:0] size (0 byte, 1 half, 2/3 word), [2] unsigned load.
- i_alu_result  in  32  byte address.
- i_memory_data  in  32  forwarded store data (rs2).
- o_stall  out  1  freeze fetch..memory stages.
- o_load_data  out  32  extended load result.
- o_load_valid  out  1  o_load_data valid this cycle.
- o_misaligned  out  1  access-fault pulse.
- o_bus_req  out  1  bus request; held until i_bus_gnt.
- o_bus_we  out  1  1 store, 0 load.
- o_bus_addr  out  32  word address, [1:0]=0.
- o_bus_wdata  out  32  lane-replicated store data.
- o_bus_wstrb  out  4  byte enables (0 on loads).
- i_bus_gnt  in  1  request accepted.
- i_bus_rvalid  in  1  read data valid; never in the grant cycle or earlier.
- i_bus_rdata  in  32  read data.

## Operation
- FSM states IDLE, REQ, WAIT, DONE. Start = IDLE & i_valid & (read|write).
- IDLE: on start, register address, funct3, we, wdata, wstrb; → REQ (or → DONE with misalign flag, see Configuration).
- REQ: o_bus_req=1, bus fields from registers. gnt: store → DONE; load → WAIT.
- WAIT: on rvalid, register extended data → DONE.
- DONE: o_load_valid=1 for loads, o_misaligned=1 if flagged; → IDLE unconditionally (EX/MEM inputs still show the finished op this cycle; must not restart).
- o_stall = start | REQ | WAIT; low in DONE, so the pipeline advances at end of DONE.
- Store: byte → wdata {4{d[7:0]}}, wstrb 0001<<a[1:0]; half → {2{d[15:0]}}, 0011<<(2·a[1]); word → d, 1111.
- Load: lane = rdata >> (8·a[1:0]); byte/half sign-extended unless funct3[2]; word passed through.
- Misaligned: half with a[0]=1; word with a[1:0]≠0.

## Timing
- Reset: state IDLE; all outputs 0 (o_bus_addr, o_bus_wdata, o_load_data included).
- Bus outputs and o_load_data registered; o_stall combinational.
- Zero-wait store: 3 cycles (IDLE, REQ+gnt, DONE). Zero-wait load: 4 cycles (IDLE, REQ+gnt, WAIT+rvalid, DONE).
- Each extra cycle without gnt/rvalid adds one stall cycle; request fields stable while o_bus_req high.
- Reset mid-access: abandon; o_bus_req low the next cycle; rvalid arriving in IDLE/REQ is ignored.
- i_valid low or neither read nor write in IDLE: no stall, no bus activity.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned start → DONE without bus activity, o_misaligned=1 in DONE, o_load_valid=0; stall for one cycle (start cycle).
- Undefined: no check; address low bits ignored for alignment (half uses a[1], word uses neither), access proceeds normally; o_misaligned tied 0.

## Structure
- Shared core package: FSM state enum, size encodings (SIZE_BYTE/HALF/WORD), strobe constants.
- One sub-module: load_align_extend (rdata, a[1:0], funct3 → 32-bit result), purely combinational.

## Test plan
- SW 0xDEADBEEF to 0x100, gnt in REQ cycle → addr 0x100, wstrb 1111, wdata 0xDEADBEEF; stall 2 cycles, then DONE.
- SB 0x000000A5 to 0x203 → addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
- LB 0x202, rdata 0x12_80_34_56 → o_load_data 0xFFFFFF80; LBU same → 0x00000080; LH 0x202 → 0x00001280.
- LW with gnt delayed 3 cycles, rvalid 2 cycles after gnt → o_stall high exactly 7 cycles, req stable throughout, o_load_valid one pulse.
- LW 0x102 with LSU_MISALIGN_TRAP_EN → no o_bus_req, o_misaligned pulse in cycle 1; without macro → bus addr 0x100, normal load.
- i_rst during WAIT, then rvalid → no o_load_valid, state IDLE, outputs 0.
